// File: rtl/stack_alu.sv
// stack_alu: signed LIFO stack machine with ADD/MUL on the top two entries and registered result/overflow.
// Optional STACK_ALU_STATUS_EN adds empty/full outputs and flags stack misuse on overflow.
module stack_alu #(
  parameter int N     = 8,
  parameter int DEPTH = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] input_data,
  input  logic [2:0]   opcode,
  output logic [N-1:0] output_data,
  output logic         overflow
`ifdef STACK_ALU_STATUS_EN
  ,
  output logic         empty,
  output logic         full
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]          sp;
  logic [N-1:0]         mem [DEPTH];
  logic [AW-1:0]        top_idx, nxt_idx;
  logic signed [N-1:0]  a, b;
  logic [N:0]           sum;
  logic [2*N-1:0]       prod;
  logic                 sum_ovf, prod_ovf;
  logic                 op_add, op_mul, op_push, op_pop;
  logic                 is_empty, is_full, has_two, misuse;
  assign op_add   = opcode == 3'b100;
  assign op_mul   = opcode == 3'b101;
  assign op_push  = opcode == 3'b110;
  assign op_pop   = opcode == 3'b111;
  assign is_empty = sp == '0;
  assign is_full  = sp == (AW+1)'(DEPTH);
  assign has_two  = sp >= (AW+1)'(2);
  assign top_idx  = AW'(sp - (AW+1)'(1));
  assign nxt_idx  = AW'(sp - (AW+1)'(2));
  assign a        = mem[top_idx];
  assign b        = mem[nxt_idx];
  // Sign-extended operands keep the low 2N product bits equal to the signed product
  assign sum      = {a[N-1], a} + {b[N-1], b};
  assign prod     = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};
  assign sum_ovf  = sum[N] ^ sum[N-1];
  assign prod_ovf = |prod[2*N-1:N-1] & ~&prod[2*N-1:N-1];
`ifdef STACK_ALU_STATUS_EN
  assign empty    = is_empty;
  assign full     = is_full;
  assign misuse   = (op_push & is_full) | (op_pop & is_empty) | ((op_add | op_mul) & ~has_two);
`else
  assign misuse   = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp          <= '0;
      output_data <= '0;
      overflow    <= 1'b0;
    end else begin
      sp          <= (op_push & ~is_full)  ? sp + (AW+1)'(1) :
                     (op_pop  & ~is_empty) ? sp - (AW+1)'(1) : sp;
      output_data <= (op_pop  & ~is_empty) ? a :
                     (op_add  & has_two)   ? sum[N-1:0] :
                     (op_mul  & has_two)   ? prod[N-1:0] : output_data;
      overflow    <= (op_add & has_two) ? sum_ovf :
                     (op_mul & has_two) ? prod_ovf : misuse;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && op_push && !is_full) mem[sp[AW-1:0]] <= input_data;
  end
endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: directed scoreboard bench for stack_alu (N=8, DEPTH=512).
module tb_stack_alu;
  localparam int N = 8;
  localparam int DEPTH = 512;
  localparam logic [2:0] NOP = 3'b000, ADD = 3'b100, MUL = 3'b101, PUSH = 3'b110, POP = 3'b111;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] input_data = '0;
  logic [2:0]   opcode = NOP;
  logic [N-1:0] output_data;
  logic         overflow;
`ifdef STACK_ALU_STATUS_EN
  logic         empty, full;
`endif
  typedef struct {
    logic [N-1:0] d;
    logic         o;
    logic         e;
  } exp_t;
  exp_t         sb[$];
  int           stk[$];
  logic [N-1:0] md = '0;
  logic         mo = 1'b0;
  int           checks = 0;
  int           fails = 0;

  stack_alu #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .input_data(input_data), .opcode(opcode),
    .output_data(output_data), .overflow(overflow)
`ifdef STACK_ALU_STATUS_EN
    , .empty(empty), .full(full)
`endif
  );

  always #5 clk = ~clk;

  task automatic model(input logic [2:0] op, input int d);
    logic signed [N-1:0] v;
    int r;
    logic bad;
    bad = 1'b0;
    v = d[N-1:0];
    mo = 1'b0;
    if (op == PUSH) begin
      if (stk.size() < DEPTH) stk.push_back(int'(v)); else bad = 1'b1;
    end else if (op == POP) begin
      if (stk.size() > 0) md = N'(stk.pop_back()); else bad = 1'b1;
    end else if (op == ADD || op == MUL) begin
      if (stk.size() >= 2) begin
        r = (op == ADD) ? stk[$] + stk[$-1] : stk[$] * stk[$-1];
        md = N'(r);
        mo = (r > 2**(N-1) - 1) || (r < -(2**(N-1)));
      end else bad = 1'b1;
    end
`ifdef STACK_ALU_STATUS_EN
    if (bad) mo = 1'b1;
`endif
    sb.push_back('{md, mo, stk.size() == 0});
  endtask

  task automatic check(input string tag);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (output_data === e.d) else begin
      fails++;
      $error("FAIL %s output_data=%0d expected %0d", tag, $signed(output_data), $signed(e.d));
    end
    checks++;
    assert (overflow === e.o) else begin
      fails++;
      $error("FAIL %s overflow=%b expected %b", tag, overflow, e.o);
    end
`ifdef STACK_ALU_STATUS_EN
    checks++;
    assert (empty === e.e) else begin
      fails++;
      $error("FAIL %s empty=%b expected %b", tag, empty, e.e);
    end
`endif
  endtask

  task automatic step(input logic [2:0] op, input int d, input string tag);
    @(negedge clk);
    opcode = op;
    input_data = d[N-1:0];
    model(op, d);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    stk.delete();
    md = '0;
    mo = 1'b0;
    #1;
    sb.push_back('{md, mo, 1'b1});
    check(tag);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = NOP;
  endtask

  initial begin
    @(negedge clk);
    reset_now("reset");
    step(NOP, 0, "nop_after_reset");
    step(PUSH, 3, "push3");
    step(PUSH, 4, "push4");
    step(ADD, 0, "add_3_4");
    step(POP, 0, "pop4");
    step(POP, 0, "pop3");
    step(POP, 0, "pop_empty");
    step(ADD, 0, "add_empty");
    step(PUSH, 100, "push100");
    step(PUSH, 50, "push50");
    step(ADD, 0, "add_ovf");
    step(NOP, 0, "nop_clears_ovf");
    step(PUSH, -8, "push_m8");
    step(PUSH, -8, "push_m8b");
    step(ADD, 0, "add_m16");
    step(MUL, 0, "mul_64");
    step(PUSH, -8, "push_m8c");
    step(PUSH, 7, "push7");
    step(MUL, 0, "mul_m56");
    step(PUSH, 16, "push16");
    step(PUSH, 8, "push8");
    step(MUL, 0, "mul_ovf");
    step(PUSH, -16, "push_m16");
    step(PUSH, 8, "push8b");
    step(MUL, 0, "mul_m128");
    step(PUSH, 127, "push127");
    step(PUSH, 1, "push1");
    step(ADD, 0, "add_127_1");
    step(PUSH, -128, "push_m128");
    step(PUSH, -1, "push_m1");
    step(ADD, 0, "add_neg_ovf");
    step(MUL, 0, "mul_m128_m1");
    @(negedge clk);
    reset_now("reset2");
    for (int x = -8; x <= 7; x++) begin
      for (int y = -8; y <= 7; y++) begin
        step(PUSH, x, "ex_push_a");
        step(PUSH, y, "ex_push_b");
        step(ADD, 0, "ex_add");
        step(MUL, 0, "ex_mul");
      end
    end
    step(PUSH, 99, "ex_push_full");
    step(ADD, 0, "ex_add_after_full");
    @(negedge clk);
    reset_now("reset3");
    for (int i = 1; i <= DEPTH; i++) step(PUSH, i, "fill");
    step(PUSH, 99, "push_when_full");
    for (int i = 0; i <= DEPTH; i++) step(POP, 0, "drain");
    step(PUSH, 5, "pre_rst_push5");
    step(PUSH, 6, "pre_rst_push6");
    step(PUSH, 7, "pre_rst_push7");
    step(POP, 0, "pre_rst_pop7");
    @(negedge clk);
    opcode = ADD;
    #2;
    reset_now("rst_mid_add");
    step(POP, 0, "pop_after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
